aposta_emissor: RTL and testbench
=================================

// Module: aposta_emissor
// PURPOSE
//   Bet transmitter: the player-side end of the lottery checker interface.
//   Latches one 5-digit bet, sends its digits one per insere pulse on
//   numero/insere, then asserts fim_jogo and captures the premio response.
//   Tracks completed games and blocks new games once MAX_JOGOS is reached.
//   Sits between the bet-entry logic and the checker in the lottery top level.
// PARAMETERS
//   NUM_DIGITS  5  digits per bet (>=2)
//   DIGIT_W     4  bits per digit
//   GAP_CYCLES  1  idle cycles between consecutive insere pulses (>=0)
//   RESP_WAIT   2  cycles after fim_jogo before premio is sampled (>=1)
//   MAX_JOGOS   5  games accepted before limite is set (1..7)
// PORTS
//   clock      in   1                     system clock; all logic on rising edge
//   reset      in   1                     synchronous, active-high
//   aposta     in   NUM_DIGITS*DIGIT_W    bet; digit 0 in MS nibble [19:16]
//   start      in   1                     request to send one game
//   premio     in   2                     checker result: 00 none, 01 P1, 10 P2
//   numero     out  DIGIT_W               current digit to checker
//   insere     out  1                     1-cycle strobe: numero valid
//   fim_jogo   out  1                     1-cycle end-of-game strobe
//   busy       out  1                     game in progress
//   done       out  1                     1-cycle pulse: resultado updated
//   resultado  out  2                     last captured premio
//   jogos      out  3                     completed games, saturating
//   limite     out  1                     jogos == MAX_JOGOS; start ignored
// BEHAVIOUR
//   Reset (any cycle, including mid-game): state IDLE. numero, insere,
//     fim_jogo, busy, done, resultado, jogos and limite all 0. Digit index and
//     gap/wait counters cleared. A partially sent game is dropped, not resumed.
//   FSM: IDLE -> SEND -> (GAP -> SEND)* -> FIM -> WAIT -> CAPTURE -> IDLE.
//   IDLE: busy=0. If start=1 and limite=0, latch aposta, set idx=0, go to SEND.
//     Start in any other state, or while limite=1, is ignored; nothing queued.
//   SEND: insere=1, numero=digit[idx], busy=1. If idx==NUM_DIGITS-1, go to FIM.
//     Otherwise idx+1, then go to GAP, or back to SEND if GAP_CYCLES==0.
//   GAP: insere=0 for exactly GAP_CYCLES cycles, then SEND. numero holds value.
//   FIM: fim_jogo=1 for one cycle. numero holds the last digit, because the
//     checker compares the final digit on the fim_jogo edge. insere=0.
//   WAIT: RESP_WAIT cycles with all strobes 0. premio is sampled on the edge
//     that ends the last WAIT cycle.
//   CAPTURE: for one cycle resultado=sampled premio (11 kept as-is), done=1,
//     jogos=min(jogos+1, MAX_JOGOS), limite=(new jogos==MAX_JOGOS). Then IDLE.
//     resultado and jogos hold until the next CAPTURE or reset.
//   Timing, with start sampled at edge 0 (defaults): insere high in cycles
//     1,3,5,7,9; fim_jogo high in cycle 10; done high in cycle 13.
//     General: insere for digit k in cycle 1+k*(GAP_CYCLES+1);
//     fim_jogo in F = 2+(NUM_DIGITS-1)*(GAP_CYCLES+1); done in F+RESP_WAIT+1.
//   insere and fim_jogo are never high in the same cycle. Both are registered
//     outputs, with no combinational path from any input.
//   aposta is sampled only at start. Later changes do not affect the game
//     in flight.
// TESTING
//   T1 aposta=20'h53820, start 1 cycle -> numero 5,3,8,2,0 with insere in
//      cycles 1,3,5,7,9; fim_jogo in cycle 10 with numero=0; done in cycle 13.
//   T2 premio=2'b01 held from cycle 10 -> resultado=01 and jogos=1 in cycle 13.
//      Next game with premio=10 -> resultado=10, jogos=2.
//   T3 pulse start in cycles 3 and 11 during a game -> no extra insere. Exactly
//      5 insere and 1 done per game.
//   T4 play 5 games -> limite=1 and jogos=5 after the 5th done. A 6th start
//      -> no insere, busy stays 0, jogos stays 5.
//   T5 reset in cycle 6 of a game -> all outputs 0 in the next cycle.
//      A fresh start then sends all 5 digits from digit 0; jogos=1 after done.
//   T6 GAP_CYCLES=0, RESP_WAIT=1 -> insere high in cycles 1-5, fim_jogo in
//      cycle 6, done in cycle 8.

Source files
------------

// File: rtl/aposta_emissor.sv
`default_nettype none
// ============================================================================
// Module   : aposta_emissor
// Purpose  : Player-side bet transmitter for the lottery checker. Latches one
//            NUM_DIGITS-digit bet on start, streams the digits one per insere
//            strobe on numero, raises fim_jogo with the last digit still on
//            numero, waits RESP_WAIT cycles, then captures premio into
//            resultado with a one-cycle done pulse. Completed games are
//            counted in jogos; once MAX_JOGOS is reached limite blocks start.
// Ports    : clock, reset        - rising-edge clock, synchronous active-high
//            aposta              - bet, digit 0 in the most significant nibble
//            start               - request to send one game (IDLE only)
//            premio              - checker result, sampled at end of WAIT
//            numero, insere      - digit bus and its 1-cycle valid strobe
//            fim_jogo            - 1-cycle end-of-game strobe
//            busy                - game in progress
//            done, resultado     - capture pulse and last captured premio
//            jogos, limite       - saturating game count and its limit flag
// Revision : 1.0  initial release
// ============================================================================
module aposta_emissor #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int RESP_WAIT  = 2,
  parameter int MAX_JOGOS  = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] aposta,
  input  logic                          start,
  input  logic [1:0]                    premio,
  output logic [DIGIT_W-1:0]            numero,
  output logic                          insere,
  output logic                          fim_jogo,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    resultado,
  output logic [2:0]                    jogos,
  output logic                          limite
);

  localparam int BET_W  = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WAIT_W = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  // Counters are loaded with (length-1) and the state ends when they hit 0.
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESP_WAIT - 1);
  localparam logic [2:0]        MAX_J     = 3'(MAX_JOGOS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_GAP     = 3'd2,
    S_FIM     = 3'd3,
    S_WAIT    = 3'd4,
    S_CAPTURE = 3'd5
  } state_t;

  state_t              state_q;
  logic [BET_W-1:0]    bet_q;
  logic [IDX_W-1:0]    idx_q;
  logic [GAP_W-1:0]    gap_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [DIGIT_W-1:0]  numero_q;
  logic                insere_q;
  logic                fim_q;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          resultado_q;
  logic [2:0]          jogos_q;
  logic                limite_q;
  logic [2:0]          jogos_d;

  // Digit k sits k digits below the top of the bet word.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [BET_W-1:0] b,
                                                  input int k);
    logic [BET_W-1:0] sh;
    sh = b >> ((NUM_DIGITS - 1 - k) * DIGIT_W);
    return sh[DIGIT_W-1:0];
  endfunction

  // Saturating increment of the completed-game counter.
  always_comb begin
    jogos_d = jogos_q;
    if (jogos_q != MAX_J) begin
      jogos_d = jogos_q + 3'd1;
    end
  end

  // Outputs are registered alongside the state: each branch sets the output
  // values that belong to the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bet_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      wait_q      <= '0;
      numero_q    <= '0;
      insere_q    <= 1'b0;
      fim_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resultado_q <= 2'b00;
      jogos_q     <= 3'd0;
      limite_q    <= 1'b0;
    end else begin
      insere_q <= 1'b0;
      fim_q    <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !limite_q) begin
            bet_q    <= aposta;
            idx_q    <= '0;
            numero_q <= digit_at(aposta, 0);
            insere_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          if (idx_q == LAST_IDX) begin
            // numero keeps the final digit through fim_jogo.
            fim_q   <= 1'b1;
            state_q <= S_FIM;
          end else begin
            idx_q <= idx_q + IDX_ONE;
            if (GAP_CYCLES == 0) begin
              numero_q <= digit_at(bet_q, int'(idx_q) + 1);
              insere_q <= 1'b1;
              state_q  <= S_SEND;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            numero_q <= digit_at(bet_q, int'(idx_q));
            insere_q <= 1'b1;
            state_q  <= S_SEND;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_FIM: begin
          wait_q  <= WAIT_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            resultado_q <= premio;
            done_q      <= 1'b1;
            jogos_q     <= jogos_d;
            limite_q    <= (jogos_d == MAX_J);
            state_q     <= S_CAPTURE;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        S_CAPTURE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign numero    = numero_q;
  assign insere    = insere_q;
  assign fim_jogo  = fim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign resultado = resultado_q;
  assign jogos     = jogos_q;
  assign limite    = limite_q;

endmodule
`default_nettype wire

// File: tb/tb_aposta_emissor.sv
`default_nettype none
// ============================================================================
// Module   : tb_aposta_emissor
// Purpose  : Self-checking bench for aposta_emissor. Two instances: default
//            timing (u_dut0) and GAP_CYCLES=0 / RESP_WAIT=1 (u_dut1). Each
//            game is compared cycle by cycle against timing and digit values
//            derived from the bet with plain arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_aposta_emissor;

  localparam int N   = 5;
  localparam int MAX = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] aposta;
  logic [1:0]  premio;
  logic        start0, start1;

  logic [3:0]  numero0, numero1;
  logic        insere0, insere1, fim0, fim1, busy0, busy1, done0, done1;
  logic [1:0]  res0, res1;
  logic [2:0]  jogos0, jogos1;
  logic        lim0, lim1;

  int errors = 0;
  int checks = 0;
  int exp_jogos [2];

  always #5 clk = ~clk;

  aposta_emissor u_dut0 (
    .clock(clk), .reset(rst), .aposta(aposta), .start(start0), .premio(premio),
    .numero(numero0), .insere(insere0), .fim_jogo(fim0), .busy(busy0),
    .done(done0), .resultado(res0), .jogos(jogos0), .limite(lim0)
  );

  aposta_emissor #(.GAP_CYCLES(0), .RESP_WAIT(1)) u_dut1 (
    .clock(clk), .reset(rst), .aposta(aposta), .start(start1), .premio(premio),
    .numero(numero1), .insere(insere1), .fim_jogo(fim1), .busy(busy1),
    .done(done1), .resultado(res1), .jogos(jogos1), .limite(lim1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Digit k of a bet: decimal-style positional arithmetic in base 16.
  function automatic int model_digit(input logic [19:0] bet, input int k);
    return (int'(bet) / (16 ** (N - 1 - k))) % 16;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, ".numero"}, int'(numero0), 0);
      check({tag, ".insere"}, int'(insere0), 0);
      check({tag, ".fim"},    int'(fim0),    0);
      check({tag, ".busy"},   int'(busy0),   0);
      check({tag, ".done"},   int'(done0),   0);
      check({tag, ".res"},    int'(res0),    0);
      check({tag, ".jogos"},  int'(jogos0),  0);
      check({tag, ".limite"}, int'(lim0),    0);
    end else begin
      check({tag, ".numero1"}, int'(numero1), 0);
      check({tag, ".insere1"}, int'(insere1), 0);
      check({tag, ".jogos1"},  int'(jogos1),  0);
      check({tag, ".limite1"}, int'(lim1),    0);
    end
  endtask

  // One game request on instance sel. start is sampled at edge 0; the loop
  // samples at the falling edge inside each cycle c.
  task automatic play(input int sel, input logic [19:0] bet, input logic [1:0] pr,
                      input bit extra_start, input string tag);
    int g, rw, f, d, n_ins, n_done, k, expd;
    bit run, e_ins, e_fim, e_done, e_busy;
    logic o_ins, o_fim, o_done, o_busy, o_lim;
    logic [3:0] o_num;
    logic [1:0] o_res;
    logic [2:0] o_jog;
    g  = (sel == 0) ? 1 : 0;
    rw = (sel == 0) ? 2 : 1;
    f  = 2 + (N - 1) * (g + 1);
    d  = f + rw + 1;
    run = (exp_jogos[sel] < MAX);
    n_ins = 0;
    n_done = 0;
    @(negedge clk);
    aposta = bet;
    premio = ~pr;
    set_start(sel, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= d + 2; c++) begin
      @(negedge clk);
      o_ins  = (sel == 0) ? insere0 : insere1;
      o_fim  = (sel == 0) ? fim0    : fim1;
      o_done = (sel == 0) ? done0   : done1;
      o_busy = (sel == 0) ? busy0   : busy1;
      o_num  = (sel == 0) ? numero0 : numero1;
      o_res  = (sel == 0) ? res0    : res1;
      o_jog  = (sel == 0) ? jogos0  : jogos1;
      o_lim  = (sel == 0) ? lim0    : lim1;
      e_ins  = run && (c < f) && (((c - 1) % (g + 1)) == 0);
      e_fim  = run && (c == f);
      e_done = run && (c == d);
      e_busy = run && (c <= d);
      if (o_ins)  n_ins++;
      if (o_done) n_done++;
      check($sformatf("%s.insere@%0d", tag, c), int'(o_ins),  int'(e_ins));
      check($sformatf("%s.fim@%0d",    tag, c), int'(o_fim),  int'(e_fim));
      check($sformatf("%s.done@%0d",   tag, c), int'(o_done), int'(e_done));
      check($sformatf("%s.busy@%0d",   tag, c), int'(o_busy), int'(e_busy));
      if (e_ins || e_fim) begin
        k = e_fim ? N - 1 : (c - 1) / (g + 1);
        check($sformatf("%s.numero@%0d", tag, c), int'(o_num), model_digit(bet, k));
      end
      if (e_done) begin
        expd = (exp_jogos[sel] + 1 > MAX) ? MAX : exp_jogos[sel] + 1;
        exp_jogos[sel] = expd;
        check({tag, ".resultado"}, int'(o_res), int'(pr));
        check({tag, ".jogos"},     int'(o_jog), expd);
        check({tag, ".limite"},    int'(o_lim), int'(expd == MAX));
      end
      // Stimulus for the following cycles.
      set_start(sel, extra_start && (c == 3 || c == 11));
      if (c == 2) aposta = 20'($urandom);
      if (c == f - 1) premio = pr;
      if (c == d) premio = ~pr;
    end
    set_start(sel, 1'b0);
    check({tag, ".n_insere"}, n_ins,  run ? N : 0);
    check({tag, ".n_done"},   n_done, run ? 1 : 0);
    if (!run) begin
      check({tag, ".jogos_hold"},  int'((sel == 0) ? jogos0 : jogos1), MAX);
      check({tag, ".limite_hold"}, int'((sel == 0) ? lim0 : lim1), 1);
    end
  endtask

  initial begin
    rst    = 1'b1;
    aposta = '0;
    premio = 2'b00;
    start0 = 1'b0;
    start1 = 1'b0;
    exp_jogos[0] = 0;
    exp_jogos[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero(0, "reset");
    check_all_zero(1, "reset");
    rst = 1'b0;

    // Directed bet, then random bets with fixed and random prizes.
    play(0, 20'h53820, 2'b01, 1'b0, "g1");
    play(0, 20'($urandom), 2'b10, 1'b0, "g2");
    play(0, 20'($urandom), 2'($urandom), 1'b1, "g3_extra_start");

    // Reset in cycle 6 of a game drops it and clears everything.
    @(negedge clk);
    aposta = 20'($urandom);
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero(0, "midreset");
    rst = 1'b0;
    exp_jogos[0] = 0;
    exp_jogos[1] = 0;

    play(0, 20'($urandom), 2'($urandom), 1'b0, "after_reset");
    for (int i = 0; i < 4; i++) begin
      play(0, 20'($urandom), 2'($urandom), 1'b0, $sformatf("fill%0d", i));
    end
    play(0, 20'($urandom), 2'($urandom), 1'b0, "over_limit");

    // Zero gap, single wait cycle.
    play(1, 20'h9A1F4, 2'b11, 1'b0, "nogap1");
    play(1, 20'($urandom), 2'($urandom), 1'b1, "nogap2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
